// File: rtl/cpu_mc_pkg.sv
// Shared encodings for the multi-cycle CPU: instruction modes, ARITH sub-ops
// and the controller state enumeration.
package cpu_mc_pkg;

    localparam logic [1:0] MODE_JUMP  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_STORE = 2'b10;
    localparam logic [1:0] MODE_ARITH = 2'b11;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_MEM   = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

endpackage

// File: rtl/cpu_mc_regfile.sv
// General-purpose register file: 2^RB entries of DW bits, two combinational
// read ports and one synchronous write port cleared by synchronous reset.
module cpu_mc_regfile #(
    parameter int DW = 8,
    parameter int RB = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RB-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RB-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [RB-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    localparam int NREG = 2 ** RB;

    logic [DW-1:0] regs_r [NREG];

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

    // Register storage: reset clears every entry, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle CPU core: FETCH / EXEC / MEM / HALT controller with handshaked
// instruction and data memory ports.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int RB = 2
) (
    input  logic              clk,
    input  logic              areset,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ready,
    input  logic [2+3*RB-1:0] imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DW-1:0]     dmem_addr,
    output logic [DW-1:0]     dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DW-1:0]     dmem_rdata,
    output logic [DW-1:0]     tb_data,
    output logic              retire,
    output logic              halted
);

    localparam int IW = 2 + 3 * RB;
    localparam int JW = IW - 2;

    state_t        state_r;
    logic [AW-1:0] pc_r;
    logic [IW-1:0] ir_r;
    logic [DW-1:0] dmem_addr_r;
    logic [DW-1:0] dmem_wdata_r;
    logic          dmem_we_r;
    logic [DW-1:0] tb_data_r;
    logic          retire_r;
    logic          halted_r;

    logic [1:0]           mode_s;
    logic [RB-1:0]        f1_s;
    logic [RB-1:0]        f2_s;
    logic [RB-1:0]        f3_s;
    logic [1:0]           op_s;
    logic signed [JW-1:0] jump_off_s;
    logic signed [RB-1:0] mem_off_s;
    logic [RB-1:0]        rd_b_idx_s;
    logic [DW-1:0]        rd_a_s;
    logic [DW-1:0]        rd_b_s;
    logic                 rf_we_s;
    logic [RB-1:0]        rf_waddr_s;
    logic [DW-1:0]        rf_wdata_s;

    assign mode_s     = ir_r[IW-1 -: 2];
    assign f1_s       = ir_r[3*RB-1 -: RB];
    assign f2_s       = ir_r[2*RB-1 -: RB];
    assign f3_s       = ir_r[RB-1:0];
    assign op_s       = f1_s[1:0];
    assign jump_off_s = ir_r[JW-1:0];
    assign mem_off_s  = f3_s;

    // A store reads its data register through port B; everything else reads F3 there.
    assign rd_b_idx_s = (mode_s == MODE_STORE) ? f1_s : f3_s;

    assign imem_req   = (state_r == ST_FETCH) && !areset;
    assign imem_addr  = pc_r;
    assign dmem_req   = (state_r == ST_MEM) && !areset;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign tb_data    = tb_data_r;
    assign retire     = retire_r;
    assign halted     = halted_r;

    cpu_mc_regfile #(
        .DW(DW),
        .RB(RB)
    ) u_regfile (
        .clk     (clk),
        .rst     (areset),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_a (f2_s),
        .rdata_a (rd_a_s),
        .raddr_b (rd_b_idx_s),
        .rdata_b (rd_b_s)
    );

    // Register write selection: ARITH results in EXEC, load data on the accepting MEM cycle.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = f2_s;
        rf_wdata_s = rd_a_s;
        if ((state_r == ST_EXEC) && (mode_s == MODE_ARITH) &&
            ((op_s == OP_ADD) || (op_s == OP_SUB))) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = f2_s;
            rf_wdata_s = (op_s == OP_SUB) ? (rd_a_s - rd_b_s) : (rd_a_s + rd_b_s);
        end else if ((state_r == ST_MEM) && dmem_ready && !dmem_we_r) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = f1_s;
            rf_wdata_s = dmem_rdata;
        end else begin
            rf_we_s    = 1'b0;
            rf_waddr_s = f2_s;
            rf_wdata_s = rd_a_s;
        end
    end

    // Controller: sequences the instruction phases and owns all registered outputs.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r      <= ST_FETCH;
            pc_r         <= {AW{1'b0}};
            ir_r         <= {IW{1'b0}};
            dmem_addr_r  <= {DW{1'b0}};
            dmem_wdata_r <= {DW{1'b0}};
            dmem_we_r    <= 1'b0;
            tb_data_r    <= {DW{1'b0}};
            retire_r     <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            retire_r <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir_r    <= imem_data;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (mode_s)
                        MODE_JUMP: begin
                            pc_r     <= pc_r + AW'(jump_off_s);
                            retire_r <= 1'b1;
                            state_r  <= ST_FETCH;
                        end
                        MODE_LOAD, MODE_STORE: begin
                            // Address and data are frozen here so they stay stable while MEM waits.
                            dmem_addr_r  <= rd_a_s + DW'(mem_off_s);
                            dmem_wdata_r <= rd_b_s;
                            dmem_we_r    <= (mode_s == MODE_STORE);
                            state_r      <= ST_MEM;
                        end
                        MODE_ARITH: begin
                            retire_r <= 1'b1;
                            if (op_s == OP_HALT) begin
                                halted_r <= 1'b1;
                                state_r  <= ST_HALT;
                            end else begin
                                pc_r    <= pc_r + AW'(1'b1);
                                state_r <= ST_FETCH;
                            end
                        end
                        default: state_r <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (!dmem_we_r) begin
                            tb_data_r <= dmem_rdata;
                        end
                        pc_r     <= pc_r + AW'(1'b1);
                        retire_r <= 1'b1;
                        state_r  <= ST_FETCH;
                    end
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc with behavioural instruction/data memories.
module tb_cpu_mc;

    logic       clk;
    logic       areset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready;
    logic [7:0] imem_data;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ready;
    logic [7:0] dmem_rdata;
    logic [7:0] tb_data;
    logic       retire;
    logic       halted;

    logic [7:0] imem [0:255];
    logic [7:0] dmem [0:255];
    logic [7:0] st_addr_log [0:15];
    logic [7:0] st_data_log [0:15];
    int         st_count = 0;

    int checks = 0;
    int errors = 0;

    cpu_mc #(.DW(8), .AW(8), .RB(2)) dut (
        .clk        (clk),
        .areset     (areset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .tb_data    (tb_data),
        .retire     (retire),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    // Accepted stores are logged so the tests can check address and data.
    always @(posedge clk) begin
        if (!areset && dmem_req && dmem_ready && dmem_we) begin
            st_addr_log[st_count[3:0]] <= dmem_addr;
            st_data_log[st_count[3:0]] <= dmem_wdata;
            st_count                   <= st_count + 1;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'hF0;
            dmem[i] = 8'h00;
        end
    endtask

    // Reset for two edges; returns on the negedge right after release (cycle 1 starts).
    task automatic do_reset();
        @(negedge clk);
        areset     = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
    endtask

    // Runs n cycles, recording in mask[k] whether retire was seen after edge k.
    task automatic run_cycles(input int n, output logic [31:0] mask);
        mask = 32'h0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            mask[k] = retire;
        end
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, expected 1", name, halted, n);
            errors++;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        @(negedge clk);
        areset     = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
            $display("FAIL reset_req_forced: imem_req=%b dmem_req=%b, expected 0 0", imem_req, dmem_req);
            errors++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (imem_addr !== 8'h00 || tb_data !== 8'h00 || retire !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL reset_state: addr=%h tb_data=%h retire=%b halted=%b, expected 00 00 0 0",
                     imem_addr, tb_data, retire, halted);
            errors++;
        end
        @(negedge clk);
        areset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            $display("FAIL reset_first_fetch: req=%b addr=%h, expected 1 00", imem_req, imem_addr);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mask;
        int          st0;
        clear_mem();
        dmem[1] = 8'h05;
        imem[0] = 8'h51;
        imem[1] = 8'hD5;
        imem[2] = 8'h91;
        st0 = st_count;
        do_reset();
        run_cycles(10, mask);
        checks++;
        if (mask !== 32'h0000_0528) begin
            $display("FAIL b2b_retire_cycles: mask=%h, expected 00000528", mask);
            errors++;
        end
        checks++;
        if (st_count != st0 + 1 || st_addr_log[st0[3:0]] !== 8'h01 || st_data_log[st0[3:0]] !== 8'h0A) begin
            $display("FAIL b2b_store: count=%0d addr=%h data=%h, expected %0d 01 0a",
                     st_count - st0, st_addr_log[st0[3:0]], st_data_log[st0[3:0]], 1);
            errors++;
        end
        checks++;
        if (tb_data !== 8'h05 || halted !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL b2b_final: tb_data=%h halted=%b req=%b, expected 05 1 0", tb_data, halted, imem_req);
            errors++;
        end
    endtask

    task automatic test_wait_states();
        logic stable;
        clear_mem();
        imem[0] = 8'hC0;
        do_reset();
        imem_ready = 1'b0;
        stable     = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || retire !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            $display("FAIL wait_fetch_hold: req/addr not held during stall, got 0 expected 1");
            errors++;
        end
        @(negedge clk);
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (retire !== 1'b0) begin
            $display("FAIL wait_retire_early: retire=%b at cycle 4, expected 0", retire);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (retire !== 1'b1 || imem_addr !== 8'h01) begin
            $display("FAIL wait_retire_c5: retire=%b pc=%h, expected 1 01", retire, imem_addr);
            errors++;
        end
    endtask

    task automatic test_wrap();
        int st0;
        clear_mem();
        dmem[1]    = 8'hFF;
        dmem[8'hFE] = 8'h01;
        imem[0] = 8'h51;
        imem[1] = 8'h62;
        imem[2] = 8'hD6;
        imem[3] = 8'h91;
        imem[4] = 8'hE6;
        imem[5] = 8'h91;
        st0 = st_count;
        do_reset();
        wait_halt(60, "wrap");
        checks++;
        if (st_count != st0 + 2) begin
            $display("FAIL wrap_store_count: got %0d expected 2", st_count - st0);
            errors++;
        end
        checks++;
        if (st_data_log[st0[3:0]] !== 8'h00) begin
            $display("FAIL wrap_add: r1=%h expected 00", st_data_log[st0[3:0]]);
            errors++;
        end
        checks++;
        if (st_data_log[(st0 + 1) % 16] !== 8'hFF) begin
            $display("FAIL wrap_sub: r1=%h expected ff", st_data_log[(st0 + 1) % 16]);
            errors++;
        end
        checks++;
        if (tb_data !== 8'h01) begin
            $display("FAIL wrap_neg_offset_load: tb_data=%h expected 01", tb_data);
            errors++;
        end
    endtask

    task automatic test_jumps();
        logic [31:0] mask;
        logic        same;
        int          rc;
        clear_mem();
        for (int i = 0; i < 5; i++) imem[i] = 8'hC0;
        imem[5] = 8'h02;
        do_reset();
        run_cycles(10, mask);
        checks++;
        if (imem_addr !== 8'h05) begin
            $display("FAIL jump_pre_pc: pc=%h expected 05", imem_addr);
            errors++;
        end
        run_cycles(2, mask);
        checks++;
        if (imem_addr !== 8'h07 || imem_req !== 1'b1 || mask[2] !== 1'b1) begin
            $display("FAIL jump_fwd: pc=%h req=%b retire=%b, expected 07 1 1", imem_addr, imem_req, mask[2]);
            errors++;
        end
        clear_mem();
        imem[0] = 8'h3F;
        do_reset();
        run_cycles(2, mask);
        checks++;
        if (imem_addr !== 8'hFF || imem_req !== 1'b1) begin
            $display("FAIL jump_back_wrap: pc=%h req=%b, expected ff 1", imem_addr, imem_req);
            errors++;
        end
        clear_mem();
        imem[0] = 8'h00;
        do_reset();
        same = 1'b1;
        rc   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (imem_addr !== 8'h00 || halted !== 1'b0) same = 1'b0;
            if (retire === 1'b1) rc++;
        end
        checks++;
        if (same !== 1'b1 || rc != 5) begin
            $display("FAIL jump_zero_loop: stable=%b retires=%0d, expected 1 5", same, rc);
            errors++;
        end
    endtask

    task automatic test_halt();
        logic quiet;
        clear_mem();
        do_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (retire !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL halt_enter: retire=%b halted=%b req=%b, expected 1 1 0", retire, halted, imem_req);
            errors++;
        end
        quiet = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (retire !== 1'b0 || imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            $display("FAIL halt_stays: activity seen while halted, got 0 expected 1");
            errors++;
        end
        do_reset();
        #1;
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            $display("FAIL halt_reset: halted=%b req=%b pc=%h, expected 0 1 00", halted, imem_req, imem_addr);
            errors++;
        end
    endtask

    task automatic test_reset_mid_mem();
        logic stable;
        int   st0;
        clear_mem();
        dmem[1] = 8'h77;
        imem[0] = 8'h51;
        do_reset();
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (dmem_req !== 1'b1 || dmem_addr !== 8'h01 || dmem_we !== 1'b0) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (stable !== 1'b1) begin
            $display("FAIL mem_wait_hold: dmem req/addr/we not held, got 0 expected 1");
            errors++;
        end
        @(negedge clk);
        areset     = 1'b1;
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0) begin
            $display("FAIL mem_reset_req: dmem_req=%b expected 0", dmem_req);
            errors++;
        end
        @(negedge clk);
        areset  = 1'b0;
        imem[0] = 8'h91;
        #1;
        checks++;
        if (imem_addr !== 8'h00 || tb_data !== 8'h00 || dmem_req !== 1'b0) begin
            $display("FAIL mem_reset_state: pc=%h tb_data=%h dmem_req=%b, expected 00 00 0", imem_addr, tb_data, dmem_req);
            errors++;
        end
        st0 = st_count;
        wait_halt(40, "mem_reset");
        checks++;
        if (st_count != st0 + 1 || st_data_log[st0[3:0]] !== 8'h00) begin
            $display("FAIL mem_reset_no_write: count=%0d r1=%h, expected 1 00", st_count - st0, st_data_log[st0[3:0]]);
            errors++;
        end
    endtask

    initial begin
        areset     = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_wrap();
        test_jumps();
        test_halt();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mc.md
CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 Parameter DW, default 8: data and register width, in bits.
REQ-002 Parameter AW, default 8: PC and instruction-address width, in bits.
REQ-003 Parameter RB, default 2: register-index width; register count is 2^RB; instruction width IW = 2+3*RB.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 areset  in  1  reset, synchronous, active-high.
REQ-006 imem_req  out  1  fetch request; held until accepted.
REQ-007 imem_addr  out  AW  fetch address, equal to PC.
REQ-008 imem_ready  in  1  fetch accepted; imem_data valid this cycle.
REQ-009 imem_data  in  IW  instruction word.
REQ-010 dmem_req  out  1  data request; held until accepted.
REQ-011 dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
REQ-012 dmem_addr  out  DW  data address.
REQ-013 dmem_wdata  out  DW  store data.
REQ-014 dmem_ready  in  1  data access accepted; dmem_rdata valid this cycle.
REQ-015 dmem_rdata  in  DW  load data.
REQ-016 tb_data  out  DW  last value loaded into any register, held until the next load.
REQ-017 retire  out  1  one-cycle pulse per completed instruction.
REQ-018 halted  out  1  core is stopped.

Function
REQ-019 Instruction fields SHALL be M=[IW-1:IW-2], F1, F2, F3, each RB bits and MSB-first below M.
REQ-020 Decode SHALL be:
- M=00: JUMP, PC += sext([IW-3:0]).
- M=01: LOAD, r[F1] = mem[r[F2]+sext(F3)].
- M=10: STORE, mem[r[F2]+sext(F3)] = r[F1].
- M=11: ARITH, with op = F1[1:0]: 00 NOP, 01 r[F2] += r[F3], 10 r[F2] -= r[F3], 11 HALT.
REQ-021 The state machine SHALL have four states:
- FETCH: imem_req=1; on imem_ready latch IR and go to EXEC.
- EXEC: JUMP/ARITH/NOP complete and return to FETCH; LOAD/STORE go to MEM; HALT goes to HALT.
- MEM: dmem_req=1; on dmem_ready complete and return to FETCH.
- HALT: terminal.
REQ-022 The non-jump next PC SHALL be PC+1; a jump target SHALL be PC of the jump plus the offset; both SHALL wrap modulo 2^AW.
REQ-023 Arithmetic and address sums SHALL wrap modulo 2^DW; no flags.
REQ-024 Latency with ready high in the first request cycle SHALL be 2 cycles for JUMP/ARITH/NOP and 3 cycles for LOAD/STORE; each ready-low cycle adds exactly one cycle.
REQ-025 While a request is pending, imem_addr, dmem_addr, dmem_we and dmem_wdata SHALL stay stable; ready SHALL be ignored when the matching req is 0.
REQ-026 A load SHALL write r[F1] and tb_data in the dmem_ready cycle; when F1==F2 the loaded value SHALL win.
REQ-027 retire SHALL pulse in the completing cycle, including for HALT; NOP SHALL change no register.
REQ-028 In HALT: halted=1, both req outputs 0, no state change until reset.
REQ-029 Jump offset 0 SHALL re-fetch the same address indefinitely; this is legal.

Reset
REQ-030 When areset=1 at a rising edge, the next state SHALL be: state FETCH, PC 0, all registers 0, tb_data 0, retire 0, halted 0.
REQ-031 While areset=1, imem_req and dmem_req SHALL be forced to 0.
REQ-032 Reset during a pending MEM access SHALL abandon it with no register write; the first fetch after reset SHALL be address 0.

Structure
REQ-033 Package cpu_mc_pkg SHALL hold the mode constants, the ARITH op constants and the state enumeration.
REQ-034 The register file SHALL be sub-module cpu_mc_regfile: parametrised (DW, RB), two combinational read ports, one synchronous write port, synchronous reset.

Verification (DW=8, AW=8, RB=2; zero-wait memory unless stated)
REQ-035 Load/add/store: mem[1]=0x05; program 0x51, 0xD5, 0x92 -> r1=0x0A, mem[2]=0x0A, tb_data=0x05, retire pulses at cycles 3, 5, 8.
REQ-036 Wait states: imem_ready low for 3 cycles on fetch at 0x00 -> imem_req held, imem_addr=0x00 stable, instruction completes at cycle 5.
REQ-037 Wrap: r1=0xFF, r2=0x01; 0xD6 -> r1=0x00; then SUB 0xE6 -> r1=0xFF.
REQ-038 Jumps: 0x02 at PC 0x05 -> next fetch 0x07; 0x3F at PC 0x00 -> next fetch 0xFF.
REQ-039 Halt: 0xF0 -> retire once, halted=1, no further imem_req; areset -> halted=0, fetch at 0x00.
REQ-040 Reset mid-MEM: load pending with dmem_ready low, areset pulsed -> dmem_req 0, target register 0, PC 0.
